// File: rtl/sec_pkg.sv
// Shared definitions for the screening lane scheduler: class encodings,
// FSM state type and the class-to-grant conversion helper.
package sec_pkg;

    localparam logic [1:0] CLS_REGULAR  = 2'b00;
    localparam logic [1:0] CLS_BUSINESS = 2'b01;
    localparam logic [1:0] CLS_VIP      = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_SCREEN
    } state_t;

    function automatic logic [2:0] cls_to_onehot(input logic [1:0] cls);
        logic [2:0] onehot;
        case (cls)
            CLS_REGULAR:  onehot = 3'b001;
            CLS_BUSINESS: onehot = 3'b010;
            CLS_VIP:      onehot = 3'b100;
            default:      onehot = 3'b000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/screening_lane_scheduler_pick.sv
// Combinational winner selection: starved classes (Regular before Business)
// override the VIP > Business > Regular fixed priority.
module aging_priority_pick
    import sec_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] starved_i,
    output logic [2:0] winner_o,
    output logic [1:0] sel_o
);

    logic [1:0] cls;

    always_comb begin
        cls = CLS_REGULAR;
        if (req_i[0] && starved_i[0]) begin
            cls = CLS_REGULAR;
        end else if (req_i[1] && starved_i[1]) begin
            cls = CLS_BUSINESS;
        end else if (req_i[2]) begin
            cls = CLS_VIP;
        end else if (req_i[1]) begin
            cls = CLS_BUSINESS;
        end else begin
            cls = CLS_REGULAR;
        end
    end

    assign sel_o    = cls;
    assign winner_o = (req_i != 3'b000) ? cls_to_onehot(cls) : 3'b000;

endmodule

// File: rtl/screening_lane_scheduler.sv
// Shares one screening lane between Regular, Business and VIP queues,
// holding each grant until lane_done or the screening timer expires.
module screening_lane_scheduler
    import sec_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned SCREEN_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       lane_done,
    output logic [2:0] grant,
    output logic [1:0] sel,
    output logic       grant_valid,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned    TW         = $clog2(SCREEN_TIMEOUT);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(SCREEN_TIMEOUT - 1);
    localparam logic [3:0]     STARVE_MAX = 4'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [1:0][3:0]  skip_q, skip_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic             grantValid_q, grantValid_d;
    logic             timeout_q, timeout_d;

    logic [1:0] starved;
    logic [2:0] winner;
    logic [1:0] winnerSel;
    logic       timerEnd;
    logic       intervalEnd;
    logic       decision;

    assign starved[0] = (skip_q[0] == STARVE_MAX);
    assign starved[1] = (skip_q[1] == STARVE_MAX);

    aging_priority_pick u_pick (
        .req_i     (req),
        .starved_i (starved),
        .winner_o  (winner),
        .sel_o     (winnerSel)
    );

    // lane_done takes precedence over the terminal timer count.
    assign timerEnd    = (state_q == ST_SCREEN) && (timer_q == TIMER_LAST);
    assign intervalEnd = (state_q == ST_SCREEN) && (lane_done || timerEnd);
    assign decision    = ((state_q == ST_IDLE) && (req != 3'b000)) || intervalEnd;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        grant_d      = grant_q;
        sel_d        = sel_q;
        grantValid_d = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != 3'b000) begin
                    state_d      = ST_SCREEN;
                    timer_d      = '0;
                    grant_d      = winner;
                    sel_d        = winnerSel;
                    grantValid_d = 1'b1;
                end
            end
            ST_SCREEN: begin
                timer_d = timer_q + TW'(1);
                if (intervalEnd) begin
                    timeout_d = timerEnd && !lane_done;
                    if (req != 3'b000) begin
                        timer_d      = '0;
                        grant_d      = winner;
                        sel_d        = winnerSel;
                        grantValid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 3'b000;
                        sel_d   = CLS_REGULAR;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Skip counters age Regular (0) and Business (1) only; VIP never ages.
    always_comb begin
        skip_d = skip_q;
        for (int i = 0; i < 2; i++) begin
            if (!req[i]) begin
                skip_d[i] = 4'd0;
            end else if (decision) begin
                if (winner[i]) begin
                    skip_d[i] = 4'd0;
                end else if (skip_q[i] != STARVE_MAX) begin
                    skip_d[i] = skip_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            skip_q       <= '0;
            grant_q      <= 3'b000;
            sel_q        <= CLS_REGULAR;
            grantValid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            skip_q       <= skip_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            grantValid_q <= grantValid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign sel         = sel_q;
    assign grant_valid = grantValid_q;
    assign busy        = (state_q == ST_SCREEN);
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_screening_lane_scheduler.sv
// Directed scoreboard bench for screening_lane_scheduler with STARVE_LIMIT=4
// and SCREEN_TIMEOUT=8; expected vector is {grant, sel, grant_valid, busy, timeout}.
module tb_screening_lane_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       lane_done;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       grant_valid;
    logic       busy;
    logic       timeout;

    typedef struct {
        string      tag;
        logic [7:0] vec;
    } expect_t;

    expect_t scoreboard[$];
    int vectorCount     = 0;
    int miscompareCount = 0;

    localparam logic [7:0] IDLE_OUT = 8'b000_00_000;
    localparam logic [7:0] V_NEW    = 8'b100_10_110;
    localparam logic [7:0] V_HOLD   = 8'b100_10_010;
    localparam logic [7:0] B_NEW    = 8'b010_01_110;
    localparam logic [7:0] B_HOLD   = 8'b010_01_010;
    localparam logic [7:0] R_NEW    = 8'b001_00_110;
    localparam logic [7:0] R_HOLD   = 8'b001_00_010;
    localparam logic [7:0] TO_PULSE = 8'b000_00_001;

    always #5 clk = ~clk;

    screening_lane_scheduler #(
        .STARVE_LIMIT   (4),
        .SCREEN_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .lane_done   (lane_done),
        .grant       (grant),
        .sel         (sel),
        .grant_valid (grant_valid),
        .busy        (busy),
        .timeout     (timeout)
    );

    task automatic checkOutput();
        expect_t    e;
        logic [7:0] obs;
        obs = {grant, sel, grant_valid, busy, timeout};
        e = scoreboard.pop_front();
        vectorCount++;
        assert (obs === e.vec) else begin
            miscompareCount++;
            $error("[TB] FAIL %s observed=%b required=%b", e.tag, obs, e.vec);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
    task automatic applyStimulus(input string tag, input logic r, input logic [2:0] rq,
                                 input logic d, input logic [7:0] expVec);
        expect_t e;
        rst       = r;
        req       = rq;
        lane_done = d;
        e.tag     = tag;
        e.vec     = expVec;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst       = 1'b1;
        req       = 3'b111;
        lane_done = 1'b0;

        for (int k = 0; k < 3; k++) applyStimulus("reset_hold", 1'b1, 3'b111, 1'b0, IDLE_OUT);
        applyStimulus("reset_first_vip", 1'b0, 3'b111, 1'b0, V_NEW);
        applyStimulus("vip_hold", 1'b0, 3'b111, 1'b0, V_HOLD);
        applyStimulus("release_to_idle", 1'b0, 3'b000, 1'b1, IDLE_OUT);
        applyStimulus("done_in_idle", 1'b0, 3'b000, 1'b1, IDLE_OUT);

        applyStimulus("b2b_business", 1'b0, 3'b010, 1'b0, B_NEW);
        applyStimulus("b2b_business_hold", 1'b0, 3'b011, 1'b0, B_HOLD);
        applyStimulus("b2b_regular", 1'b0, 3'b001, 1'b1, R_NEW);
        applyStimulus("b2b_to_idle", 1'b0, 3'b000, 1'b1, IDLE_OUT);

        applyStimulus("starve_vip_first", 1'b0, 3'b101, 1'b0, V_NEW);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("starve_vip_hold", 1'b0, 3'b101, 1'b0, V_HOLD);
            applyStimulus("starve_vip_hold", 1'b0, 3'b101, 1'b0, V_HOLD);
            applyStimulus("starve_vip_regrant", 1'b0, 3'b101, 1'b1, V_NEW);
        end
        applyStimulus("starve_vip_hold", 1'b0, 3'b101, 1'b0, V_HOLD);
        applyStimulus("starve_vip_hold", 1'b0, 3'b101, 1'b0, V_HOLD);
        applyStimulus("starve_regular_wins", 1'b0, 3'b101, 1'b1, R_NEW);
        applyStimulus("starve_regular_hold", 1'b0, 3'b101, 1'b0, R_HOLD);
        applyStimulus("starve_regular_hold", 1'b0, 3'b101, 1'b0, R_HOLD);
        applyStimulus("starve_vip_resumes", 1'b0, 3'b101, 1'b1, V_NEW);
        applyStimulus("starve_to_idle", 1'b0, 3'b000, 1'b1, IDLE_OUT);

        applyStimulus("timeout_grant", 1'b0, 3'b010, 1'b0, B_NEW);
        for (int k = 0; k < 7; k++) applyStimulus("timeout_busy", 1'b0, 3'b000, 1'b0, B_HOLD);
        applyStimulus("timeout_pulse", 1'b0, 3'b000, 1'b0, TO_PULSE);
        applyStimulus("timeout_after", 1'b0, 3'b000, 1'b0, IDLE_OUT);

        applyStimulus("collide_grant", 1'b0, 3'b100, 1'b0, V_NEW);
        for (int k = 0; k < 7; k++) applyStimulus("collide_busy", 1'b0, 3'b000, 1'b0, V_HOLD);
        applyStimulus("collide_no_timeout", 1'b0, 3'b000, 1'b1, IDLE_OUT);
        applyStimulus("collide_after", 1'b0, 3'b000, 1'b0, IDLE_OUT);

        applyStimulus("rstmid_grant", 1'b0, 3'b001, 1'b0, R_NEW);
        applyStimulus("rstmid_hold", 1'b0, 3'b000, 1'b0, R_HOLD);
        applyStimulus("rstmid_reset", 1'b1, 3'b000, 1'b0, IDLE_OUT);
        applyStimulus("rstmid_after", 1'b0, 3'b000, 1'b0, IDLE_OUT);

        applyStimulus("abandon_vip1", 1'b0, 3'b101, 1'b0, V_NEW);
        applyStimulus("abandon_vip2", 1'b0, 3'b101, 1'b1, V_NEW);
        applyStimulus("abandon_drop", 1'b0, 3'b100, 1'b0, V_HOLD);
        for (int k = 0; k < 4; k++) applyStimulus("abandon_fresh_loss", 1'b0, 3'b101, 1'b1, V_NEW);
        applyStimulus("abandon_regular_wins", 1'b0, 3'b101, 1'b1, R_NEW);
        applyStimulus("abandon_to_idle", 1'b0, 3'b000, 1'b1, IDLE_OUT);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
